// File: rtl/ram_pkg.sv
// Shared types and helpers for the synchronous data RAM.
package ram_pkg;

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } ram_state_e;

    // Byte-offset bits of an address: log2 of the bytes per word.
    function automatic int calc_off(input int data_width);
        return $clog2(data_width / 8);
    endfunction

    // Word-index bits of an address: log2 of the number of words.
    function automatic int calc_iw(input int depth);
        return $clog2(depth);
    endfunction

    // True when the parameter set describes a buildable RAM.
    function automatic bit params_legal(input int data_width, input int addr_width,
                                        input int depth, input int rd_latency);
        bit ok;
        ok = 1'b1;
        if (rd_latency != 1 && rd_latency != 2)                     ok = 1'b0;
        if (depth < 2 || (depth & (depth - 1)) != 0)                ok = 1'b0;
        if (data_width < 8 || (data_width % 8) != 0)                ok = 1'b0;
        if (addr_width < calc_iw(depth) + calc_off(data_width))     ok = 1'b0;
        return ok;
    endfunction

endpackage

// File: rtl/ram_bank.sv
// Plain storage array: byte-masked synchronous write, registered read.
// Holds no control logic so it maps directly onto FPGA block RAM.
module ram_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4096,
    parameter int IW         = $clog2(DEPTH)
) (
    input  logic                    clk,
    input  logic                    wr_en,
    input  logic [IW-1:0]           wr_idx,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_mask,
    input  logic                    rd_en,
    input  logic [IW-1:0]           rd_idx,
    output logic [DATA_WIDTH-1:0]   rd_data
);

    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [DATA_WIDTH-1:0] rd_data_d;

    // Update only the enabled bytes of the addressed word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < NB; k++) begin
                if (wr_mask[k]) begin
                    mem_q[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
                end
            end
        end
    end

    // Read register loads on a read and otherwise holds (read-before-write).
    always_comb begin
        rd_data_d = rd_data_q;
        if (rd_en) begin
            rd_data_d = mem_q[rd_idx];
        end
    end

    // Registered read output.
    always_ff @(posedge clk) begin
        rd_data_q <= rd_data_d;
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/ram_sync.sv
// Single-clock 1R/1W data RAM with byte-masked writes, valid-tagged
// registered reads of latency 1 or 2, write-first collision bypass and an
// optional zero-fill sequence after reset.
module ram_sync
    import ram_pkg::*;
#(
    parameter int DATA_WIDTH   = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int DEPTH        = 4096,
    parameter int RD_LATENCY   = 1,
    parameter int CLEAR_ON_RST = 1
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_rst,
    input  logic                    i_ram_rd_valid,
    output logic                    o_ram_rd_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ram_rd_addr,
    output logic                    o_ram_rd_valid,
    output logic [DATA_WIDTH-1:0]   o_ram_rd_data,
    input  logic                    i_ram_wr_valid,
    output logic                    o_ram_wr_ready,
    input  logic [ADDR_WIDTH-1:0]   i_ram_wr_addr,
    input  logic [DATA_WIDTH-1:0]   i_ram_wr_data,
    input  logic [DATA_WIDTH/8-1:0] i_ram_wr_mask,
    output logic                    o_ram_busy
);

    localparam int NB  = DATA_WIDTH / 8;
    localparam int OFF = calc_off(DATA_WIDTH);
    localparam int IW  = calc_iw(DEPTH);

    if (!params_legal(DATA_WIDTH, ADDR_WIDTH, DEPTH, RD_LATENCY)) begin : g_param_check
        $error("ram_sync: illegal parameter combination");
    end

    ram_state_e            state_q, state_d;
    logic [IW-1:0]         cnt_q, cnt_d;
    logic                  rd_v1_q, rd_v1_d;
    logic [DATA_WIDTH-1:0] byp_data_q, byp_data_d;
    logic [NB-1:0]         byp_mask_q, byp_mask_d;

    logic [IW-1:0]         rd_idx, wr_idx;
    logic                  run, rd_acc, wr_acc;
    logic                  bank_wr_en;
    logic [IW-1:0]         bank_wr_idx;
    logic [DATA_WIDTH-1:0] bank_wr_data;
    logic [NB-1:0]         bank_wr_mask;
    logic [DATA_WIDTH-1:0] bank_rd_data;
    logic [DATA_WIDTH-1:0] rd1_data;
    logic                  unused_addr_bits;

    // Offset bits and bits above the index are deliberately ignored.
    assign rd_idx           = i_ram_rd_addr[IW+OFF-1:OFF];
    assign wr_idx           = i_ram_wr_addr[IW+OFF-1:OFF];
    assign unused_addr_bits = ^{i_ram_rd_addr, i_ram_wr_addr};

    // Readies follow the state only; nothing is accepted while in reset.
    assign run            = (state_q == S_RUN);
    assign o_ram_rd_ready = run;
    assign o_ram_wr_ready = run;
    assign o_ram_busy     = (state_q == S_CLEAR);
    assign rd_acc         = i_ram_rd_valid & run & ~i_sys_rst;
    assign wr_acc         = i_ram_wr_valid & run & ~i_sys_rst;

    // Clear sequence walks cnt over every word once, then hands over to S_RUN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_CLEAR) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == IW'(DEPTH - 1)) begin
                state_d = S_RUN;
            end
        end
    end

    // State and clear-counter registers.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            state_q <= (CLEAR_ON_RST != 0) ? S_CLEAR : S_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Bank write port is owned by the clear sequence until it finishes.
    always_comb begin
        bank_wr_en   = wr_acc;
        bank_wr_idx  = wr_idx;
        bank_wr_data = i_ram_wr_data;
        bank_wr_mask = i_ram_wr_mask;
        if (state_q == S_CLEAR) begin
            bank_wr_en   = ~i_sys_rst;
            bank_wr_idx  = cnt_q;
            bank_wr_data = '0;
            bank_wr_mask = '1;
        end
    end

    ram_bank #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .IW         (IW)
    ) u_bank (
        .clk     (i_sys_clk),
        .wr_en   (bank_wr_en),
        .wr_idx  (bank_wr_idx),
        .wr_data (bank_wr_data),
        .wr_mask (bank_wr_mask),
        .rd_en   (rd_acc),
        .rd_idx  (rd_idx),
        .rd_data (bank_rd_data)
    );

    // Capture the same-cycle write bytes so the read sees write-first data;
    // a zero bypass mask means no collision.
    always_comb begin
        rd_v1_d    = rd_acc;
        byp_data_d = i_ram_wr_data;
        byp_mask_d = '0;
        if (rd_acc && wr_acc && (rd_idx == wr_idx)) begin
            byp_mask_d = i_ram_wr_mask;
        end
    end

    // First read stage registers; reset drops any in-flight read.
    always_ff @(posedge i_sys_clk) begin
        if (i_sys_rst) begin
            rd_v1_q    <= 1'b0;
            byp_data_q <= '0;
            byp_mask_q <= '0;
        end else begin
            rd_v1_q    <= rd_v1_d;
            byp_data_q <= byp_data_d;
            byp_mask_q <= byp_mask_d;
        end
    end

    // Merge bypassed write bytes over the old word read from the bank.
    always_comb begin
        rd1_data = bank_rd_data;
        for (int k = 0; k < NB; k++) begin
            if (byp_mask_q[k]) begin
                rd1_data[8*k +: 8] = byp_data_q[8*k +: 8];
            end
        end
    end

    if (RD_LATENCY == 1) begin : g_lat1
        assign o_ram_rd_valid = rd_v1_q;
        assign o_ram_rd_data  = rd_v1_q ? rd1_data : '0;
    end else begin : g_lat2
        logic                  rd_v2_q, rd_v2_d;
        logic [DATA_WIDTH-1:0] rd_data2_q, rd_data2_d;

        // Extra output stage carries already-zeroed data.
        always_comb begin
            rd_v2_d    = rd_v1_q;
            rd_data2_d = rd_v1_q ? rd1_data : '0;
        end

        // Second read stage registers; reset drops any in-flight read.
        always_ff @(posedge i_sys_clk) begin
            if (i_sys_rst) begin
                rd_v2_q    <= 1'b0;
                rd_data2_q <= '0;
            end else begin
                rd_v2_q    <= rd_v2_d;
                rd_data2_q <= rd_data2_d;
            end
        end

        assign o_ram_rd_valid = rd_v2_q;
        assign o_ram_rd_data  = rd_data2_q;
    end

endmodule
